// File: rtl/control_sequencer_if.sv
// Control bus of the 8-bit computer sequencer: decode inputs (opcode, flags)
// and the per-register strobes that drive the shared tri-state bus.
interface control_sequencer_if #(
  parameter int STEP_W = 3
);
  logic [3:0]        opcode;
  logic              flag_carry;
  logic              flag_zero;
  logic              pc_out, pc_inc, pc_load;
  logic              mar_in, ram_out, ram_in;
  logic              ir_in, ir_out;
  logic              a_in, a_out, b_in;
  logic              alu_out, alu_sub, flags_in;
  logic              out_in;
  logic              halted;
  logic [STEP_W-1:0] step;

  // Sequencer side
  modport master (
    input  opcode, flag_carry, flag_zero,
    output pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted, step
  );

  // Datapath side
  modport slave (
    output opcode, flag_carry, flag_zero,
    input  pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted, step
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded fetch/decode/execute sequencer. Step counter plus run/halt
// state; all strobes are a combinational decode so they hold for the cycle.
module control_sequencer #(
  parameter int STEP_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  control_sequencer_if.master   bus
);
  typedef enum logic {S_RUN, S_HALT} state_t;

  typedef struct packed {
    logic pc_out, pc_inc, pc_load;
    logic mar_in, ram_out, ram_in;
    logic ir_in, ir_out;
    logic a_in, a_out, b_in;
    logic alu_out, alu_sub, flags_in;
    logic out_in;
  } ctrl_t;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  ctrl_t             ctl, ctl_o;
  logic              last;

  // State register; reset abandons any instruction and restarts at T0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-step and strobe decode from (step, opcode, flags, state)
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ctl     = '0;
    last    = 1'b0;
    if (state_q == S_RUN) begin
      if (step_q == T0) begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1;
        step_d = T1;
      end else if (step_q == T1) begin
        ctl.ram_out = 1'b1; ctl.ir_in = 1'b1; ctl.pc_inc = 1'b1;
        step_d = T2;
      end else if (step_q == T2 || step_q == T3 || step_q == T4) begin
        // Any step an opcode does not use is unreachable: no strobes, back to T0
        last = 1'b1;
        case (bus.opcode)
          4'h1, 4'h4: begin
            if (step_q == T2) begin
              ctl.ir_out = 1'b1; ctl.mar_in = 1'b1; last = 1'b0;
            end else if (step_q == T3) begin
              if (bus.opcode == 4'h1) begin ctl.ram_out = 1'b1; ctl.a_in = 1'b1; end
              else begin ctl.a_out = 1'b1; ctl.ram_in = 1'b1; end
            end
          end
          4'h2, 4'h3: begin
            if (step_q == T2) begin
              ctl.ir_out = 1'b1; ctl.mar_in = 1'b1; last = 1'b0;
            end else if (step_q == T3) begin
              ctl.ram_out = 1'b1; ctl.b_in = 1'b1;
              ctl.alu_sub = bus.opcode[0]; last = 1'b0;
            end else begin
              ctl.alu_out = 1'b1; ctl.a_in = 1'b1; ctl.flags_in = 1'b1;
              ctl.alu_sub = bus.opcode[0];
            end
          end
          4'h5: if (step_q == T2) begin ctl.ir_out = 1'b1; ctl.a_in = 1'b1; end
          4'h6: if (step_q == T2) begin ctl.ir_out = 1'b1; ctl.pc_load = 1'b1; end
          4'h7: if (step_q == T2 && bus.flag_carry) begin ctl.ir_out = 1'b1; ctl.pc_load = 1'b1; end
          4'h8: if (step_q == T2 && bus.flag_zero) begin ctl.ir_out = 1'b1; ctl.pc_load = 1'b1; end
          4'hE: if (step_q == T2) begin ctl.a_out = 1'b1; ctl.out_in = 1'b1; end
          4'hF: if (step_q == T2) begin state_d = S_HALT; last = 1'b0; end
          default: ;
        endcase
        if (last) step_d = T0;
        else if (state_d == S_RUN) step_d = step_q + T1;
      end else begin
        step_d = T0;
      end
    end
  end

  // Reset overrides every strobe for the cycle it is held
  assign ctl_o = reset ? '0 : ctl;

  assign bus.pc_out   = ctl_o.pc_out;
  assign bus.pc_inc   = ctl_o.pc_inc;
  assign bus.pc_load  = ctl_o.pc_load;
  assign bus.mar_in   = ctl_o.mar_in;
  assign bus.ram_out  = ctl_o.ram_out;
  assign bus.ram_in   = ctl_o.ram_in;
  assign bus.ir_in    = ctl_o.ir_in;
  assign bus.ir_out   = ctl_o.ir_out;
  assign bus.a_in     = ctl_o.a_in;
  assign bus.a_out    = ctl_o.a_out;
  assign bus.b_in     = ctl_o.b_in;
  assign bus.alu_out  = ctl_o.alu_out;
  assign bus.alu_sub  = ctl_o.alu_sub;
  assign bus.flags_in = ctl_o.flags_in;
  assign bus.out_in   = ctl_o.out_in;
  assign bus.halted   = (state_q == S_HALT);
  assign bus.step     = step_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: the driver expands each instruction into its microprogram
// (list of control words) and queues one expectation per cycle; a monitor
// on the falling edge pops and compares.
module tb_control_sequencer;
  localparam int STEP_W = 3;

  // Control word bit order: pc_out pc_inc pc_load mar_in ram_out ram_in ir_in
  // ir_out a_in a_out b_in alu_out alu_sub flags_in out_in
  localparam logic [14:0] PC_OUT = 15'h4000, PC_INC = 15'h2000, PC_LOAD = 15'h1000;
  localparam logic [14:0] MAR_IN = 15'h0800, RAM_OUT = 15'h0400, RAM_IN = 15'h0200;
  localparam logic [14:0] IR_IN  = 15'h0100, IR_OUT = 15'h0080, A_IN = 15'h0040;
  localparam logic [14:0] A_OUT  = 15'h0020, B_IN = 15'h0010, ALU_OUT = 15'h0008;
  localparam logic [14:0] ALU_SUB = 15'h0004, FLAGS_IN = 15'h0002, OUT_IN = 15'h0001;

  typedef struct {
    logic [14:0]       w;
    logic [STEP_W-1:0] stp;
    logic              hlt;
    logic              full;   // 0: only the strobes are meaningful (reset cycle)
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  logic [14:0] prog[$];
  int checks = 0;
  int failures = 0;

  control_sequencer_if #(.STEP_W(STEP_W)) bus();
  control_sequencer #(.STEP_W(STEP_W)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  function automatic logic [14:0] dut_word();
    return {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_in, bus.ram_out, bus.ram_in,
            bus.ir_in, bus.ir_out, bus.a_in, bus.a_out, bus.b_in, bus.alu_out,
            bus.alu_sub, bus.flags_in, bus.out_in};
  endfunction

  // Reference microprogram: fetch words followed by the opcode's execute words
  task automatic build(input logic [3:0] op, input logic c, input logic z);
    logic [14:0] s;
    prog.delete();
    prog.push_back(PC_OUT | MAR_IN);
    prog.push_back(RAM_OUT | IR_IN | PC_INC);
    s = (op == 4'h3) ? ALU_SUB : 15'h0;
    case (op)
      4'h1: begin prog.push_back(IR_OUT | MAR_IN); prog.push_back(RAM_OUT | A_IN); end
      4'h2, 4'h3: begin
        prog.push_back(IR_OUT | MAR_IN);
        prog.push_back(RAM_OUT | B_IN | s);
        prog.push_back(ALU_OUT | A_IN | FLAGS_IN | s);
      end
      4'h4: begin prog.push_back(IR_OUT | MAR_IN); prog.push_back(A_OUT | RAM_IN); end
      4'h5: prog.push_back(IR_OUT | A_IN);
      4'h6: prog.push_back(IR_OUT | PC_LOAD);
      4'h7: prog.push_back(c ? (IR_OUT | PC_LOAD) : 15'h0);
      4'h8: prog.push_back(z ? (IR_OUT | PC_LOAD) : 15'h0);
      4'hE: prog.push_back(A_OUT | OUT_IN);
      default: prog.push_back(15'h0);
    endcase
  endtask

  // One cycle: drive inputs just after the edge and queue what must be seen
  task automatic cyc(input logic rst, input logic [3:0] op, input logic c, input logic z,
                     input logic [14:0] w, input int stp, input logic hlt, input logic full);
    exp_t e;
    #1;
    reset = rst; bus.opcode = op; bus.flag_carry = c; bus.flag_zero = z;
    e.w = w; e.stp = STEP_W'(stp); e.hlt = hlt; e.full = full;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b1, 4'($urandom_range(15)), 1'($urandom), 1'($urandom), 15'h0, 0, 1'b0, 1'b0);
  endtask

  // Run one instruction; abort_at < length asserts reset in that step
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input int abort_at);
    build(op, c, z);
    for (int i = 0; i < prog.size(); i++) begin
      if (i == abort_at) begin do_reset(); return; end
      cyc(1'b0, op, c, z, prog[i], i, 1'b0, 1'b1);
    end
    if (op == 4'hF) begin
      repeat (10) cyc(1'b0, 4'($urandom_range(15)), 1'($urandom), 1'($urandom), 15'h0, 2, 1'b1, 1'b1);
      do_reset();
    end
  endtask

  // Monitor: one expectation per cycle, plus the bus single-driver rule
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (dut_word() !== e.w) begin
        failures++;
        $display("FAIL ctrl: got %h want %h (step=%0d op=%h)", dut_word(), e.w, bus.step, bus.opcode);
      end
      if (e.full) begin
        checks++;
        if (bus.step !== e.stp || bus.halted !== e.hlt) begin
          failures++;
          $display("FAIL step/halted: got %0d/%b want %0d/%b", bus.step, bus.halted, e.stp, e.hlt);
        end
      end
      checks++;
      if ($countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out}) > 1) begin
        failures++;
        $display("FAIL bus_drive: drivers=%b want at most one",
                 {bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out});
      end
    end
  end

  initial begin
    reset = 1'b1; bus.opcode = 4'h0; bus.flag_carry = 1'b0; bus.flag_zero = 1'b0;
    @(posedge clk);
    do_reset();
    // Fetch after reset, then ADD and SUB
    run_instr(4'h2, 1'b0, 1'b0, 99);
    run_instr(4'h3, 1'b0, 1'b0, 99);
    // Conditional jumps both ways
    run_instr(4'h7, 1'b0, 1'b1, 99);
    run_instr(4'h7, 1'b1, 1'b0, 99);
    run_instr(4'h8, 1'b1, 1'b0, 99);
    run_instr(4'h8, 1'b0, 1'b1, 99);
    // Halt, hold, reset out
    run_instr(4'hF, 1'b0, 1'b0, 99);
    // Reset in T3 of LDA, then a clean LDA
    run_instr(4'h1, 1'b0, 1'b0, 3);
    run_instr(4'h1, 1'b0, 1'b0, 99);
    // Sweep every opcode against every flag combination
    for (int op = 0; op < 16; op++)
      for (int f = 0; f < 4; f++)
        run_instr(4'(op), f[0], f[1], 99);
    // Random instruction stream with occasional mid-instruction reset
    for (int n = 0; n < 300; n++)
      run_instr(4'($urandom_range(15)), 1'($urandom), 1'($urandom),
                ($urandom_range(19) == 0) ? int'($urandom_range(4)) : 99);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
